// File: rtl/serv_bus_arbiter.sv
// Three-master round-robin Wishbone arbiter (ibus, dbus, ext) onto one slave port.
// One classic-cycle transfer at a time; silent slaves are ended with a forced ack/err.
module serv_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  input  logic [31:0] i_ext_adr,
  input  logic [31:0] i_ext_dat,
  input  logic [3:0]  i_ext_sel,
  input  logic        i_ext_we,
  input  logic        i_ext_cyc,
  output logic [31:0] o_ext_rdt,
  output logic        o_ext_ack,
  output logic        o_ext_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    owner, owner_nxt, last, last_nxt, pick;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          own_cyc, tout, done, ack_any;

  // Rotating priority: search starts at the master after the last one granted.
  always_comb begin
    case (last)
      2'd1:    pick = i_dbus_cyc ? 2'd2 : i_ext_cyc  ? 2'd3 : i_ibus_cyc ? 2'd1 : 2'd0;
      2'd2:    pick = i_ext_cyc  ? 2'd3 : i_ibus_cyc ? 2'd1 : i_dbus_cyc ? 2'd2 : 2'd0;
      default: pick = i_ibus_cyc ? 2'd1 : i_dbus_cyc ? 2'd2 : i_ext_cyc  ? 2'd3 : 2'd0;
    endcase
  end

  always_comb begin
    case (owner)
      2'd1:    own_cyc = i_ibus_cyc;
      2'd2:    own_cyc = i_dbus_cyc;
      2'd3:    own_cyc = i_ext_cyc;
      default: own_cyc = 1'b0;
    endcase
  end

  // A real slave ack in the timeout cycle takes precedence over the forced one.
  assign tout = (TIMEOUT != 0) && (tcnt == TLAST) && !i_wb_ack;
  assign done = i_wb_ack || tout || !own_cyc;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= IDLE;
      owner <= 2'd0;
      last  <= 2'd3;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: if (pick != 2'd0) begin
        state_nxt = GRANT;
        owner_nxt = pick;
        last_nxt  = pick;
        tcnt_nxt  = '0;
      end
      GRANT: if (done) begin
        state_nxt = IDLE;
        owner_nxt = 2'd0;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_wb_adr = 32'd0;
    o_wb_dat = 32'd0;
    o_wb_sel = 4'd0;
    o_wb_we  = 1'b0;
    case (owner)
      2'd1: begin
        o_wb_adr = i_ibus_adr;
        o_wb_sel = 4'hF;
      end
      2'd2: begin
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
      end
      2'd3: begin
        o_wb_adr = i_ext_adr;
        o_wb_dat = i_ext_dat;
        o_wb_sel = i_ext_sel;
        o_wb_we  = i_ext_we;
      end
      default: ;
    endcase
  end

  // Reset overrides cyc/ack/err even while a transfer is in flight.
  assign ack_any    = !i_rst && (i_wb_ack || tout);
  assign o_wb_cyc   = own_cyc && !i_rst;
  assign o_ibus_ack = (owner == 2'd1) && ack_any;
  assign o_dbus_ack = (owner == 2'd2) && ack_any;
  assign o_ext_ack  = (owner == 2'd3) && ack_any;
  assign o_dbus_err = (owner == 2'd2) && !i_rst && tout;
  assign o_ext_err  = (owner == 2'd3) && !i_rst && tout;
  assign o_ibus_rdt = i_wb_rdt;
  assign o_dbus_rdt = i_wb_rdt;
  assign o_ext_rdt  = i_wb_rdt;
  assign o_grant    = owner;
endmodule
